regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised integer register file for the npc core; successor to the 2-read/1-write file.
- N combinational read ports, one synchronous write port, synchronous reset of all registers.
- Per-register pending-write scoreboard (outstanding-write counters) so decode can detect RAW hazards.
- Sits between decode/issue (reads, issue handshake) and writeback (write port).

Parameters:
- DATA_WIDTH, 32, bits per register
- REG_NUM, 32, number of architectural registers
- REG_NUM_BIT, 5, address width; must satisfy 2**REG_NUM_BIT >= REG_NUM
- NUM_RD, 2, number of read ports
- PEND_W, 2, width of each pending-write counter; max outstanding writes per register = 2**PEND_W-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- raddr  in  NUM_RD*REG_NUM_BIT  packed read addresses; port i = bits [i*REG_NUM_BIT +: REG_NUM_BIT]
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, same packing
- rbusy  out  NUM_RD  1 = register read by port i has pending count != 0
- wen  in  1  writeback write enable
- waddr  in  REG_NUM_BIT  writeback destination
- wdata  in  DATA_WIDTH  writeback data
- iss_valid  in  1  issue of an instruction that will write iss_rd
- iss_rd  in  REG_NUM_BIT  destination of issuing instruction
- iss_ready  out  1  issue can be accepted this cycle
- flush  in  1  pipeline flush; clears all pending counters

Behaviour:
- Reset: on a posedge with rst=1, every register is cleared to 0 and every pending counter to 0. rst overrides wen, iss_valid and flush in that cycle.
- Outputs after reset: rdata = 0 for all ports, rbusy = 0, iss_ready = 1.
- Register 0 is hardwired:
  - Reads of address 0 return 0 with rbusy = 0.
  - Writes to address 0 are discarded.
  - Issues to rd = 0 always handshake, and counter 0 never changes.
- Addresses >= REG_NUM:
  - Reads return 0 with rbusy = 0.
  - Writes are ignored.
  - Issues handshake but change no counter.
- Read: combinational, zero latency. rdata[i] = rf[raddr[i]].
- Write: rf[waddr] <= wdata at posedge when wen=1. The new value is visible on rdata the cycle after.
- Issue handshake:
  - Fires when iss_valid & iss_ready at a posedge.
  - iss_ready = 0 only when cnt[iss_rd] == max and there is no same-cycle writeback to that register (wen & waddr == iss_rd).
  - iss_ready is otherwise combinationally 1 and does not depend on iss_valid.
- Counter update per register r, per cycle:
  - inc = issue fire with iss_rd == r.
  - dec = wen with waddr == r and cnt[r] != 0.
  - inc & dec: counter unchanged.
  - inc only: counter + 1.
  - dec only: counter - 1.
  - A writeback to a register with cnt == 0 still writes the data; it never underflows the counter.
- flush:
  - All counters are set to 0 at the posedge.
  - A same-cycle write still updates rf.
  - A same-cycle issue is dropped from the scoreboard; iss_ready stays as computed.
- rbusy reflects the registered counters only: no same-cycle issue or writeback effect.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wen=1, waddr == raddr[i] and waddr != 0, rdata[i] = wdata (write-through forwarding).
  - In the same case, rbusy[i] = 1 only if cnt > 1 (the completing write resolves one pending write).
- Undefined:
  - rdata returns stored contents only.
  - rbusy follows cnt alone.
  - A same-cycle write is seen one cycle later.

Decomposition:
- Shared package npc_pkg: DATA_WIDTH, REG_NUM, REG_NUM_BIT defaults and the reg_addr_t / word_t typedefs, shared with decode and writeback.
- One natural sub-module, regfile_sb_ctr: a single PEND_W-bit up/down saturating counter with inc, dec, clr, rst and an at_max flag, instantiated REG_NUM-1 times via generate.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset then read: assert rst for 1 cycle with wen=1, waddr=3, wdata=32'hFFFF_FFFF -> rf[3]=0; all rdata=0, rbusy=0, iss_ready=1.
- x0 protection: write waddr=0, wdata=32'hDEAD_BEEF, then read raddr[0]=0 -> rdata=0. Issue iss_rd=0 four times -> iss_ready stays 1 and rbusy stays 0.
- Scoreboard saturation (PEND_W=2): issue rd=5 three times -> rbusy=1 for reads of x5 and iss_ready=0 with iss_rd=5. Same cycle wen=1, waddr=5 -> iss_ready=1, and an issue that fires leaves cnt=3.
- Simultaneous events: cnt[7]=1, issue rd=7 and writeback x7=32'h1234 in the same cycle -> cnt[7]=1, rf[7]=32'h1234 next cycle.
- Flush: cnt[9]=2 and cnt[10]=1, pulse flush -> rbusy=0 on x9 and x10 next cycle. A write to x9 in the flush cycle with value 32'h55 is visible.
- Bypass (REGFILE_BYPASS_EN defined): wen=1, waddr=4, wdata=32'hCAFE, raddr[1]=4 in the same cycle -> rdata[1]=32'hCAFE combinationally. Without the macro -> old value that cycle, 32'hCAFE the next cycle.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared widths and register/word types for decode, regfile and writeback.
package npc_pkg;
    localparam int NPC_DATA_WIDTH  = 32;
    localparam int NPC_REG_NUM     = 32;
    localparam int NPC_REG_NUM_BIT = 5;
    typedef logic [NPC_REG_NUM_BIT-1:0] reg_addr_t;
    typedef logic [NPC_DATA_WIDTH-1:0]  word_t;
endpackage

// File: rtl/regfile_sb_ctr.sv
// regfile_sb_ctr: pending-write up/down counter, saturating at max, never underflowing.
module regfile_sb_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              at_max_o
);
    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              dn;
    assign at_max_o = &cnt_q;
    assign dn       = dec_i & (|cnt_q);
    assign cnt_o    = cnt_q;
    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i == dn) ? cnt_q : inc_i ? (at_max_o ? cnt_q : cnt_q + PEND_W'(1)) : cnt_q - PEND_W'(1);
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile_sb
    import npc_pkg::*;
#(
    parameter int DATA_WIDTH  = NPC_DATA_WIDTH,
    parameter int REG_NUM     = NPC_REG_NUM,
    parameter int REG_NUM_BIT = NPC_REG_NUM_BIT,
    parameter int NUM_RD      = 2,
    parameter int PEND_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*REG_NUM_BIT-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rdata,
    output logic [NUM_RD-1:0]             rbusy,
    input  logic                          wen,
    input  logic [REG_NUM_BIT-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          iss_valid,
    input  logic [REG_NUM_BIT-1:0]        iss_rd,
    output logic                          iss_ready,
    input  logic                          flush
);
    localparam int REG_SPACE = 2**REG_NUM_BIT;
    // Every encodable address gets an entry; x0 and unimplemented ones read as constant zero.
    logic [DATA_WIDTH-1:0] rf_rd  [REG_SPACE];
    logic [PEND_W-1:0]     cnt_rd [REG_SPACE];
    logic [REG_SPACE-1:0]  at_max;
    logic                  iss_fire;
    assign iss_ready = ~at_max[iss_rd] | (wen & (waddr == iss_rd));
    assign iss_fire  = iss_valid & iss_ready;
    for (genvar j = 0; j < REG_SPACE; j++) begin : g_reg
        if (j > 0 && j < REG_NUM) begin : g_live
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  hit_w;
            assign hit_w  = wen & (waddr == REG_NUM_BIT'(j));
            assign data_d = hit_w ? wdata : data_q;
            always_ff @(posedge clk) begin
                data_q <= rst ? '0 : data_d;
            end
            regfile_sb_ctr #(.PEND_W(PEND_W)) u_ctr (
                .clk      (clk),
                .rst      (rst),
                .inc_i    (iss_fire & (iss_rd == REG_NUM_BIT'(j))),
                .dec_i    (hit_w),
                .clr_i    (flush),
                .cnt_o    (cnt_rd[j]),
                .at_max_o (at_max[j])
            );
            assign rf_rd[j] = data_q;
        end else begin : g_nil
            assign rf_rd[j]  = '0;
            assign cnt_rd[j] = '0;
            assign at_max[j] = 1'b0;
        end
    end
`ifdef REGFILE_BYPASS_EN
    logic [REG_SPACE-1:0] legal;
    for (genvar j = 0; j < REG_SPACE; j++) begin : g_legal
        assign legal[j] = (j > 0 && j < REG_NUM);
    end
`endif
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_NUM_BIT-1:0] a;
        assign a = raddr[p*REG_NUM_BIT +: REG_NUM_BIT];
`ifdef REGFILE_BYPASS_EN
        logic byp;
        // The completing write resolves one pending write, so only deeper queues stay busy.
        assign byp = wen & (waddr == a) & legal[a];
        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = byp ? wdata : rf_rd[a];
        assign rbusy[p] = byp ? (cnt_rd[a] > PEND_W'(1)) : |cnt_rd[a];
`else
        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf_rd[a];
        assign rbusy[p] = |cnt_rd[a];
`endif
    end
endmodule
